rvfi_retire_gen: RTL and testbench

- Producer side of the RVFI trace interface for single-issue, multi-cycle cores.
- Collects per-instruction events from the core (issue, memory access, writeback, retire) and assembles them into one registered RVFI record per retired instruction.
- Drives one RVFI channel (NRET=1) into the formal checkers and the trace monitor.

---
 rtl/rvfi_retire_gen_pkg.sv | 51 +++++
 rtl/rvfi_retire_gen_if.sv | 48 ++++
 rtl/rvfi_retire_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_rvfi_retire_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_retire_gen_pkg.sv
// rvfi_gen_pkg: shared types for the RVFI retirement record generator.
//   state_e      - collector FSM state (IDLE, ACTIVE)
//   ORDER_W      - width of the retirement index
//   REC_XLEN/REC_ILEN - record field widths; set REC_XLEN to 64 for RV64 builds
//   rvfi_rec_t   - one packed RVFI record
//   trap_mask()  - clears the fields a trapped instruction must not report
package rvfi_gen_pkg;

  localparam int unsigned ORDER_W  = 64;
  localparam int unsigned REC_XLEN = 32;
  localparam int unsigned REC_ILEN = 32;
  localparam int unsigned REC_MASK = REC_XLEN / 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  typedef struct packed {
    logic [REC_ILEN-1:0] insn;
    logic                trap;
    logic                halt;
    logic                intr;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [4:0]          rd_addr;
    logic [REC_XLEN-1:0] rs1_rdata;
    logic [REC_XLEN-1:0] rs2_rdata;
    logic [REC_XLEN-1:0] rd_wdata;
    logic [REC_XLEN-1:0] pc_rdata;
    logic [REC_XLEN-1:0] pc_wdata;
    logic [REC_XLEN-1:0] mem_addr;
    logic [REC_XLEN-1:0] mem_rdata;
    logic [REC_XLEN-1:0] mem_wdata;
    logic [REC_MASK-1:0] mem_rmask;
    logic [REC_MASK-1:0] mem_wmask;
  } rvfi_rec_t;

  // A trapped instruction architecturally writes neither rd nor memory.
  function automatic rvfi_rec_t trap_mask(input rvfi_rec_t rec);
    rvfi_rec_t r;
    r = rec;
    if (r.trap) begin
      r.rd_addr   = '0;
      r.rd_wdata  = '0;
      r.mem_wmask = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/rvfi_retire_gen_if.sv
// rvfi_retire_gen_if: single RVFI channel (NRET=1).
//   master - producer (rvfi_retire_gen) drives every field
//   slave  - formal checker / trace monitor observes every field
interface rvfi_retire_gen_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ILEN = 32
);
  import rvfi_gen_pkg::*;

  logic               rvfi_valid;
  logic [ORDER_W-1:0] rvfi_order;
  logic [ILEN-1:0]    rvfi_insn;
  logic               rvfi_trap;
  logic               rvfi_halt;
  logic               rvfi_intr;
  logic [4:0]         rvfi_rs1_addr;
  logic [4:0]         rvfi_rs2_addr;
  logic [4:0]         rvfi_rd_addr;
  logic [XLEN-1:0]    rvfi_rs1_rdata;
  logic [XLEN-1:0]    rvfi_rs2_rdata;
  logic [XLEN-1:0]    rvfi_rd_wdata;
  logic [XLEN-1:0]    rvfi_pc_rdata;
  logic [XLEN-1:0]    rvfi_pc_wdata;
  logic [XLEN-1:0]    rvfi_mem_addr;
  logic [XLEN/8-1:0]  rvfi_mem_rmask;
  logic [XLEN/8-1:0]  rvfi_mem_wmask;
  logic [XLEN-1:0]    rvfi_mem_rdata;
  logic [XLEN-1:0]    rvfi_mem_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
           rvfi_mem_rdata, rvfi_mem_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
           rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
           rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
           rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
           rvfi_mem_rdata, rvfi_mem_wdata
  );

endinterface

// File: rtl/rvfi_retire_gen.sv
// rvfi_retire_gen: assembles per-instruction core events into one registered
// RVFI record per retired instruction (single-issue, multi-cycle cores).
//
// Ports:
//   clock, reset        - clock; synchronous active-low reset
//   issue_*             - instruction entered execution (insn, pc, operands)
//   mem_*               - memory access event of the in-flight instruction
//   wb_*                - register writeback event
//   retire_*            - instruction completes (next pc, trap, halt)
//   rvfi (master)       - RVFI record, rvfi_valid pulses one cycle per record
//   proto_err           - sticky event-ordering violation, cleared by reset
//
// Build option: define RVFI_RETIRE_GEN_INTR_EN to flag the record following
// a trapped one with rvfi_intr=1. Without it rvfi_intr is tied low.
//
// state  | meaning
// IDLE   | no instruction in flight
// ACTIVE | issued instruction collecting mem/wb events until retire
module rvfi_retire_gen
  import rvfi_gen_pkg::*;
#(
  parameter int unsigned XLEN = REC_XLEN,
  parameter int unsigned ILEN = REC_ILEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ILEN-1:0]   issue_insn,
  input  logic [XLEN-1:0]   issue_pc,
  input  logic [4:0]        issue_rs1_addr,
  input  logic [4:0]        issue_rs2_addr,
  input  logic [XLEN-1:0]   issue_rs1_rdata,
  input  logic [XLEN-1:0]   issue_rs2_rdata,
  input  logic              mem_valid,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_rmask,
  input  logic [XLEN/8-1:0] mem_wmask,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc_wdata,
  input  logic              retire_trap,
  input  logic              retire_halt,
  output logic              proto_err,
  rvfi_retire_gen_if.master rvfi
);

  state_e             state_q, state_d;
  rvfi_rec_t          cap_q, cap_d;
  rvfi_rec_t          out_q, out_d;
  logic               valid_q, valid_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic               err_q, err_d;
  logic               mem_seen_q, mem_seen_d;
  logic               wb_seen_q, wb_seen_d;

  rvfi_rec_t          fresh_rec;
  rvfi_rec_t          live_rec;
  rvfi_rec_t          ret_rec;
  logic               emit;
  logic               intr_cur;

  always_comb begin
    fresh_rec           = '0;
    fresh_rec.insn      = issue_insn;
    fresh_rec.pc_rdata  = issue_pc;
    fresh_rec.rs1_addr  = issue_rs1_addr;
    fresh_rec.rs2_addr  = issue_rs2_addr;
    fresh_rec.rs1_rdata = issue_rs1_rdata;
    fresh_rec.rs2_rdata = issue_rs2_rdata;

    // Same-cycle mem/wb events fold into whichever instruction retires or
    // stays in flight this cycle.
    live_rec = (state_q == ACTIVE) ? cap_q : fresh_rec;
    if (mem_valid) begin
      live_rec.mem_addr  = mem_addr;
      live_rec.mem_rmask = mem_rmask;
      live_rec.mem_wmask = mem_wmask;
      live_rec.mem_rdata = mem_rdata;
      live_rec.mem_wdata = mem_wdata;
    end
    if (wb_valid) begin
      live_rec.rd_addr  = wb_addr;
      live_rec.rd_wdata = (wb_addr == 5'd0) ? '0 : wb_data;
    end

    ret_rec          = live_rec;
    ret_rec.pc_wdata = retire_pc_wdata;
    ret_rec.trap     = retire_trap;
    ret_rec.halt     = retire_halt;
    ret_rec.intr     = intr_cur;
    ret_rec          = trap_mask(ret_rec);
  end

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    order_d    = valid_q ? order_q + 1'b1 : order_q;
    err_d      = err_q;
    mem_seen_d = mem_seen_q;
    wb_seen_d  = wb_seen_q;
    emit       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (issue_valid && retire_valid) begin
          emit  = 1'b1;
        end else if (issue_valid) begin
          cap_d      = fresh_rec;
          mem_seen_d = 1'b0;
          wb_seen_d  = 1'b0;
          state_d    = ACTIVE;
        end else if (retire_valid) begin
          err_d = 1'b1;
        end
      end
      ACTIVE: begin
        if ((mem_valid && mem_seen_q) || (wb_valid && wb_seen_q)) begin
          err_d = 1'b1;
        end
        if (retire_valid) begin
          emit = 1'b1;
          if (issue_valid) begin
            cap_d      = fresh_rec;
            mem_seen_d = 1'b0;
            wb_seen_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cap_d      = live_rec;
          mem_seen_d = mem_seen_q | mem_valid;
          wb_seen_d  = wb_seen_q | wb_valid;
          if (issue_valid) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      out_d   = ret_rec;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      order_q    <= '0;
      err_q      <= 1'b0;
      mem_seen_q <= 1'b0;
      wb_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      order_q    <= order_d;
      err_q      <= err_d;
      mem_seen_q <= mem_seen_d;
      wb_seen_q  <= wb_seen_d;
    end
  end

`ifdef RVFI_RETIRE_GEN_INTR_EN
  logic intr_q, intr_d;

  // Every emitted record either arms (trap) or consumes/clears the flag.
  always_comb begin
    intr_d = intr_q;
    if (emit) begin
      intr_d = retire_trap;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= intr_d;
    end
  end

  assign intr_cur = intr_q;
`else
  assign intr_cur = 1'b0;
`endif

  assign proto_err           = err_q;
  assign rvfi.rvfi_valid     = valid_q;
  assign rvfi.rvfi_order     = order_q;
  assign rvfi.rvfi_insn      = out_q.insn;
  assign rvfi.rvfi_trap      = out_q.trap;
  assign rvfi.rvfi_halt      = out_q.halt;
  assign rvfi.rvfi_intr      = out_q.intr;
  assign rvfi.rvfi_rs1_addr  = out_q.rs1_addr;
  assign rvfi.rvfi_rs2_addr  = out_q.rs2_addr;
  assign rvfi.rvfi_rd_addr   = out_q.rd_addr;
  assign rvfi.rvfi_rs1_rdata = out_q.rs1_rdata;
  assign rvfi.rvfi_rs2_rdata = out_q.rs2_rdata;
  assign rvfi.rvfi_rd_wdata  = out_q.rd_wdata;
  assign rvfi.rvfi_pc_rdata  = out_q.pc_rdata;
  assign rvfi.rvfi_pc_wdata  = out_q.pc_wdata;
  assign rvfi.rvfi_mem_addr  = out_q.mem_addr;
  assign rvfi.rvfi_mem_rmask = out_q.mem_rmask;
  assign rvfi.rvfi_mem_wmask = out_q.mem_wmask;
  assign rvfi.rvfi_mem_rdata = out_q.mem_rdata;
  assign rvfi.rvfi_mem_wdata = out_q.mem_wdata;

endmodule

// File: tb/tb_rvfi_retire_gen.sv
// Self-checking bench for rvfi_retire_gen: expected records are queued when
// retire is driven and compared field by field when rvfi_valid is seen.
module tb_rvfi_retire_gen;

`ifdef RVFI_RETIRE_GEN_INTR_EN
  localparam logic INTR_ON = 1'b1;
`else
  localparam logic INTR_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid;
  logic [31:0] issue_insn, issue_pc;
  logic [4:0]  issue_rs1_addr, issue_rs2_addr;
  logic [31:0] issue_rs1_rdata, issue_rs2_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        retire_valid;
  logic [31:0] retire_pc_wdata;
  logic        retire_trap, retire_halt;
  logic        proto_err;

  rvfi_retire_gen_if #(.XLEN(32), .ILEN(32)) rvfi_bus ();

  rvfi_retire_gen #(.XLEN(32), .ILEN(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_insn      (issue_insn),
    .issue_pc        (issue_pc),
    .issue_rs1_addr  (issue_rs1_addr),
    .issue_rs2_addr  (issue_rs2_addr),
    .issue_rs1_rdata (issue_rs1_rdata),
    .issue_rs2_rdata (issue_rs2_rdata),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_rmask       (mem_rmask),
    .mem_wmask       (mem_wmask),
    .mem_rdata       (mem_rdata),
    .mem_wdata       (mem_wdata),
    .wb_valid        (wb_valid),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .retire_valid    (retire_valid),
    .retire_pc_wdata (retire_pc_wdata),
    .retire_trap     (retire_trap),
    .retire_halt     (retire_halt),
    .proto_err       (proto_err),
    .rvfi            (rvfi_bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn, pc_rdata, pc_wdata, rd_wdata;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [31:0] mem_addr, mem_rdata, mem_wdata;
    logic [4:0]  rd_addr;
    logic [3:0]  rmask, wmask;
    logic        trap, halt, intr;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_order = '0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    issue_valid = 0; issue_insn = '0; issue_pc = '0;
    issue_rs1_addr = '0; issue_rs2_addr = '0;
    issue_rs1_rdata = '0; issue_rs2_rdata = '0;
    mem_valid = 0; mem_addr = '0; mem_rmask = '0; mem_wmask = '0;
    mem_rdata = '0; mem_wdata = '0;
    wb_valid = 0; wb_addr = '0; wb_data = '0;
    retire_valid = 0; retire_pc_wdata = '0; retire_trap = 0; retire_halt = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  // Operands are derived from the pc so each instruction is distinguishable.
  task automatic set_issue(input logic [31:0] pc, input logic [31:0] insn);
    issue_valid = 1; issue_pc = pc; issue_insn = insn;
    issue_rs1_addr = 5'd1; issue_rs2_addr = 5'd2;
    issue_rs1_rdata = 32'h1111_0000 | pc;
    issue_rs2_rdata = 32'h2222_0000 | pc;
  endtask

  task automatic set_mem(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] rd, input logic [31:0] wd);
    mem_valid = 1; mem_addr = a; mem_rmask = rm; mem_wmask = wm;
    mem_rdata = rd; mem_wdata = wd;
  endtask

  task automatic set_wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic set_retire(input logic [31:0] npc, input logic trap, input logic halt);
    retire_valid = 1; retire_pc_wdata = npc; retire_trap = trap; retire_halt = halt;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insn, input logic [31:0] npc,
                      input logic [4:0] rd, input logic [31:0] rdw,
                      input logic [31:0] ma, input logic [3:0] rm, input logic [3:0] wm,
                      input logic [31:0] mrd, input logic [31:0] mwd,
                      input logic trap, input logic halt, input logic intr);
    exp_t e;
    e.order = exp_order; e.insn = insn; e.pc_rdata = pc; e.pc_wdata = npc;
    e.rs1_rdata = 32'h1111_0000 | pc; e.rs2_rdata = 32'h2222_0000 | pc;
    e.rd_addr = rd; e.rd_wdata = rdw; e.mem_addr = ma; e.rmask = rm; e.wmask = wm;
    e.mem_rdata = mrd; e.mem_wdata = mwd; e.trap = trap; e.halt = halt; e.intr = intr;
    sb.push_back(e);
    exp_order++;
  endtask

  always @(negedge clock) begin
    if (rvfi_bus.rvfi_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 64'(rvfi_bus.rvfi_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("order",     rvfi_bus.rvfi_order,            e.order);
        check_eq("insn",      64'(rvfi_bus.rvfi_insn),        64'(e.insn));
        check_eq("pc_rdata",  64'(rvfi_bus.rvfi_pc_rdata),    64'(e.pc_rdata));
        check_eq("pc_wdata",  64'(rvfi_bus.rvfi_pc_wdata),    64'(e.pc_wdata));
        check_eq("rs1_addr",  64'(rvfi_bus.rvfi_rs1_addr),    64'd1);
        check_eq("rs2_addr",  64'(rvfi_bus.rvfi_rs2_addr),    64'd2);
        check_eq("rs1_rdata", 64'(rvfi_bus.rvfi_rs1_rdata),   64'(e.rs1_rdata));
        check_eq("rs2_rdata", 64'(rvfi_bus.rvfi_rs2_rdata),   64'(e.rs2_rdata));
        check_eq("rd_addr",   64'(rvfi_bus.rvfi_rd_addr),     64'(e.rd_addr));
        check_eq("rd_wdata",  64'(rvfi_bus.rvfi_rd_wdata),    64'(e.rd_wdata));
        check_eq("mem_addr",  64'(rvfi_bus.rvfi_mem_addr),    64'(e.mem_addr));
        check_eq("mem_rmask", 64'(rvfi_bus.rvfi_mem_rmask),   64'(e.rmask));
        check_eq("mem_wmask", 64'(rvfi_bus.rvfi_mem_wmask),   64'(e.wmask));
        check_eq("mem_rdata", 64'(rvfi_bus.rvfi_mem_rdata),   64'(e.mem_rdata));
        check_eq("mem_wdata", 64'(rvfi_bus.rvfi_mem_wdata),   64'(e.mem_wdata));
        check_eq("trap",      64'(rvfi_bus.rvfi_trap),        64'(e.trap));
        check_eq("halt",      64'(rvfi_bus.rvfi_halt),        64'(e.halt));
        check_eq("intr",      64'(rvfi_bus.rvfi_intr),        64'(e.intr));
      end
    end
  end

  initial begin
    clear_in();
    reset = 0;
    repeat (3) step();
    @(negedge clock);
    check_eq("rst_valid",    64'(rvfi_bus.rvfi_valid),    64'd0);
    check_eq("rst_order",    rvfi_bus.rvfi_order,         64'd0);
    check_eq("rst_proto",    64'(proto_err),              64'd0);
    check_eq("rst_pc_rdata", 64'(rvfi_bus.rvfi_pc_rdata), 64'd0);
    check_eq("rst_insn",     64'(rvfi_bus.rvfi_insn),     64'd0);
    reset = 1;

    // Back-to-back single-cycle ADDs
    set_issue(32'h100, 32'h0020_82b3); set_wb(5'd5, 32'd7); set_retire(32'h104, 0, 0);
    push(32'h100, 32'h0020_82b3, 32'h104, 5'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_issue(32'h104, 32'h0020_82b3); set_wb(5'd5, 32'd7); set_retire(32'h108, 0, 0);
    push(32'h104, 32'h0020_82b3, 32'h108, 5'd5, 32'd7, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    @(negedge clock);
    check_eq("hold_pc_rdata", 64'(rvfi_bus.rvfi_pc_rdata), 64'h104);
    check_eq("hold_order",    rvfi_bus.rvfi_order,         64'd2);

    // Multi-cycle load
    set_issue(32'h200, 32'h0000_a183); step();
    step();
    set_mem(32'h1000, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0); step();
    set_wb(5'd3, 32'hDEAD_BEEF); set_retire(32'h204, 0, 0);
    push(32'h200, 32'h0000_a183, 32'h204, 5'd3, 32'hDEAD_BEEF,
         32'h1000, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    step();

    // Trapping store: rd and wmask suppressed
    set_issue(32'h300, 32'h0020_a023); step();
    set_mem(32'h2000, 4'h0, 4'hF, 32'h0, 32'h1234_5678); step();
    set_wb(5'd1, 32'd9); set_retire(32'h80, 1, 0);
    push(32'h300, 32'h0020_a023, 32'h80, 5'd0, 32'd0,
         32'h2000, 4'h0, 4'h0, 32'h0, 32'h1234_5678, 1, 0, 0);
    step();

    // x0 write, single cycle with same-cycle store
    set_issue(32'h400, 32'h0550_0013); set_wb(5'd0, 32'h55);
    set_mem(32'h3000, 4'h0, 4'h3, 32'h0, 32'hAB); set_retire(32'h404, 0, 0);
    push(32'h400, 32'h0550_0013, 32'h404, 5'd0, 32'd0,
         32'h3000, 4'h0, 4'h3, 32'h0, 32'hAB, 0, 0, INTR_ON);
    step();

    // Back-to-back in ACTIVE: retire + issue together
    set_issue(32'h500, 32'h0000_0013); step();
    set_retire(32'h504, 0, 0); set_issue(32'h504, 32'h0770_0393);
    push(32'h500, 32'h0000_0013, 32'h504, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_wb(5'd7, 32'h77); set_retire(32'h508, 0, 0);
    push(32'h504, 32'h0770_0393, 32'h508, 5'd7, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // Protocol errors
    @(negedge clock);
    check_eq("proto_clean", 64'(proto_err), 64'd0);
    set_retire(32'h999, 0, 0); step();
    @(negedge clock);
    check_eq("proto_stray_retire", 64'(proto_err), 64'd1);
    set_issue(32'h600, 32'h0040_0213); step();
    set_issue(32'h700, 32'h0000_0000); step();
    @(negedge clock);
    check_eq("proto_sticky", 64'(proto_err), 64'd1);
    set_wb(5'd4, 32'd4); set_retire(32'h604, 0, 1);
    push(32'h600, 32'h0040_0213, 32'h604, 5'd4, 32'd4, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();

    // Reset mid-instruction
    set_issue(32'h800, 32'h0000_0013); step();
    reset = 0; step();
    @(negedge clock);
    check_eq("rst2_proto", 64'(proto_err),           64'd0);
    check_eq("rst2_order", rvfi_bus.rvfi_order,      64'd0);
    check_eq("rst2_valid", 64'(rvfi_bus.rvfi_valid), 64'd0);
    reset = 1;
    exp_order = '0;
    set_retire(32'h804, 0, 0); step();
    @(negedge clock);
    check_eq("rst2_stray", 64'(proto_err), 64'd1);
    set_issue(32'h900, 32'h0000_0013); set_retire(32'h904, 0, 0);
    push(32'h900, 32'h0000_0013, 32'h904, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    // Duplicate writeback: last one wins, proto_err raised
    reset = 0; step();
    reset = 1;
    exp_order = '0;
    set_issue(32'hA00, 32'h0010_0113); step();
    set_wb(5'd2, 32'd1); step();
    @(negedge clock);
    check_eq("wb_once_proto", 64'(proto_err), 64'd0);
    set_wb(5'd2, 32'd2); step();
    @(negedge clock);
    check_eq("wb_dup_proto", 64'(proto_err), 64'd1);
    set_retire(32'hA04, 0, 0);
    push(32'hA00, 32'h0010_0113, 32'hA04, 5'd2, 32'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
